ysyx_23060201_idu: RTL and testbench

Registered RV32I instruction-decode stage feeding the ALU: accepts fetched instructions from the IFU over a valid/ready channel and emits decoded ALU control, operand selects, immediate and register indices over a second valid/ready channel. A two-entry skid buffer (main + skid) keeps `in_ready` a pure register output, so no combinational path runs from `out_ready` to `in_ready`.

---
 rtl/ysyx_23060201_idu.sv | 215 +++++++++++++++++++++
 tb/tb_ysyx_23060201_idu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060201_idu.sv
// ============================================================================
// Module  : ysyx_23060201_idu
// Brief   : Registered RV32I decode stage with a two-entry skid buffer.
//           Optional macro YSYX_23060201_IDU_RV32E_EN restricts registers to x0-x15.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_23060201_idu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_ctl,
  output logic [1:0]  out_src1_sel,
  output logic [1:0]  out_src2_sel,
  output logic [31:0] out_imm,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_rd_wen,
  output logic [31:0] out_pc,
  output logic        out_illegal
);

  localparam logic [6:0] c_OPC_OP     = 7'b0110011;
  localparam logic [6:0] c_OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] c_OPC_LUI    = 7'b0110111;
  localparam logic [6:0] c_OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OPC_JAL    = 7'b1101111;
  localparam logic [6:0] c_OPC_JALR   = 7'b1100111;
  localparam logic [6:0] c_OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OPC_STORE  = 7'b0100011;
  localparam logic [6:0] c_OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] c_SRC1_RS1  = 2'b00;
  localparam logic [1:0] c_SRC1_PC   = 2'b01;
  localparam logic [1:0] c_SRC1_ZERO = 2'b10;
  localparam logic [1:0] c_SRC2_RS2  = 2'b00;
  localparam logic [1:0] c_SRC2_IMM  = 2'b01;
  localparam logic [1:0] c_SRC2_FOUR = 2'b10;

  typedef struct packed {
    logic [3:0]  alu_ctl;
    logic [1:0]  src1_sel;
    logic [1:0]  src2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] pc;
    logic        illegal;
  } dec_t;

  logic [6:0]  w_opcode;
  logic [2:0]  w_f3;
  logic [6:0]  w_f7;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic        w_bad;
  dec_t        w_dec;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_imm_i  = {{20{in_inst[31]}}, in_inst[31:20]};
  assign w_imm_s  = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign w_imm_b  = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign w_imm_u  = {in_inst[31:12], 12'b0};
  assign w_imm_j  = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

`ifdef YSYX_23060201_IDU_RV32E_EN
  logic w_rv32e_bad;
  // Only the register fields the format really reads or writes are range-checked.
  always_comb begin
    w_rv32e_bad = 1'b0;
    if (w_opcode != c_OPC_LUI && w_opcode != c_OPC_AUIPC && w_opcode != c_OPC_JAL)
      w_rv32e_bad = w_rv32e_bad | in_inst[19];
    if (w_opcode == c_OPC_OP || w_opcode == c_OPC_STORE || w_opcode == c_OPC_BRANCH)
      w_rv32e_bad = w_rv32e_bad | in_inst[24];
    if (w_opcode != c_OPC_STORE && w_opcode != c_OPC_BRANCH)
      w_rv32e_bad = w_rv32e_bad | in_inst[11];
  end
`endif

  always_comb begin
    w_dec          = '0;
    w_dec.rs1      = in_inst[19:15];
    w_dec.rs2      = in_inst[24:20];
    w_dec.rd       = in_inst[11:7];
    w_dec.pc       = in_pc;
    w_dec.src1_sel = c_SRC1_RS1;
    w_dec.src2_sel = c_SRC2_IMM;
    w_bad          = 1'b0;
    case (w_opcode)
      c_OPC_OP: begin
        w_dec.src2_sel = c_SRC2_RS2;
        w_dec.imm      = w_imm_i;
        w_dec.alu_ctl  = {w_f7[5], w_f3};
        w_dec.rd_wen   = 1'b1;
        w_bad = !((w_f7 == 7'h00) || (w_f7 == 7'h20 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
      end
      c_OPC_OPIMM: begin
        w_dec.imm     = w_imm_i;
        w_dec.alu_ctl = {1'b0, w_f3};
        w_dec.rd_wen  = 1'b1;
        // Shifts carry a zero-extended shamt; funct7 only qualifies the shift kind.
        if (w_f3 == 3'b101) begin
          w_dec.imm     = {27'b0, in_inst[24:20]};
          w_dec.alu_ctl = {w_f7[5], 3'b101};
          w_bad         = !(w_f7 == 7'h00 || w_f7 == 7'h20);
        end else if (w_f3 == 3'b001) begin
          w_dec.imm = {27'b0, in_inst[24:20]};
          w_bad     = (w_f7 != 7'h00);
        end
      end
      c_OPC_LUI: begin
        w_dec.src1_sel = c_SRC1_ZERO;
        w_dec.imm      = w_imm_u;
        w_dec.rd_wen   = 1'b1;
      end
      c_OPC_AUIPC: begin
        w_dec.src1_sel = c_SRC1_PC;
        w_dec.imm      = w_imm_u;
        w_dec.rd_wen   = 1'b1;
      end
      c_OPC_JAL, c_OPC_JALR: begin
        w_dec.src1_sel = c_SRC1_PC;
        w_dec.src2_sel = c_SRC2_FOUR;
        w_dec.imm      = (w_opcode == c_OPC_JAL) ? w_imm_j : w_imm_i;
        w_dec.rd_wen   = 1'b1;
      end
      c_OPC_LOAD: begin
        w_dec.imm    = w_imm_i;
        w_dec.rd_wen = 1'b1;
      end
      c_OPC_STORE: w_dec.imm = w_imm_s;
      c_OPC_BRANCH: begin
        w_dec.src2_sel = c_SRC2_RS2;
        w_dec.imm      = w_imm_b;
        case (w_f3[2:1])
          2'b00:   w_dec.alu_ctl = 4'b1000;
          2'b10:   w_dec.alu_ctl = 4'b0010;
          2'b11:   w_dec.alu_ctl = 4'b0011;
          default: w_bad = 1'b1;
        endcase
      end
      default: w_bad = 1'b1;
    endcase
`ifdef YSYX_23060201_IDU_RV32E_EN
    w_bad = w_bad | w_rv32e_bad;
`endif
    w_dec.illegal = w_bad;
    if (w_bad) w_dec.alu_ctl = 4'b0000;
    w_dec.rd_wen = w_dec.rd_wen & !w_bad & (w_dec.rd != 5'd0);
  end

  dec_t r_main, r_skid;
  logic r_main_valid, r_skid_valid, r_in_ready;
  logic w_accept, w_main_open, w_skid_valid_nxt;

  assign w_accept    = in_valid & r_in_ready;
  assign w_main_open = !r_main_valid | out_ready;
  // Skid can only fill while main is stalled; in_ready is already low when skid is full.
  assign w_skid_valid_nxt = w_main_open ? 1'b0 : (r_skid_valid | w_accept);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main       <= '0;
      r_skid       <= '0;
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_main_open) begin
        if (r_skid_valid) begin
          r_main       <= r_skid;
          r_main_valid <= 1'b1;
        end else begin
          r_main_valid <= w_accept;
          if (w_accept) r_main <= w_dec;
        end
      end else if (w_accept) begin
        r_skid <= w_dec;
      end
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_main_valid;
  assign out_alu_ctl  = r_main.alu_ctl;
  assign out_src1_sel = r_main.src1_sel;
  assign out_src2_sel = r_main.src2_sel;
  assign out_imm      = r_main.imm;
  assign out_rs1      = r_main.rs1;
  assign out_rs2      = r_main.rs2;
  assign out_rd       = r_main.rd;
  assign out_rd_wen   = r_main.rd_wen;
  assign out_pc       = r_main.pc;
  assign out_illegal  = r_main.illegal;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060201_idu.sv
// ============================================================================
// Module  : tb_ysyx_23060201_idu
// Brief   : Directed self-checking bench for the ysyx_23060201_idu decode stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_23060201_idu;

  logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_inst, in_pc, out_imm, out_pc;
  logic [3:0]  out_alu_ctl;
  logic [1:0]  out_src1_sel, out_src2_sel;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic        out_rd_wen, out_illegal;

  int n_checks = 0;
  int n_errors = 0;

`ifdef YSYX_23060201_IDU_RV32E_EN
  localparam logic c_RV32E = 1'b1;
`else
  localparam logic c_RV32E = 1'b0;
`endif

  ysyx_23060201_idu dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctl(out_alu_ctl), .out_src1_sel(out_src1_sel), .out_src2_sel(out_src2_sel),
    .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_rd_wen(out_rd_wen), .out_pc(out_pc), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the next falling edge sees the registered result.
  task automatic drive(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int rcvd;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_imm", out_imm, 0);
    chk("rst_ctl", out_alu_ctl, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_wen", out_rd_wen, 0);
    rst_n = 1'b1;
    @(negedge clk);

    drive(32'h002081B3, 32'h1000);            // add x3,x1,x2
    chk("add_valid", out_valid, 1);
    chk("add_ctl", out_alu_ctl, 4'b0000);
    chk("add_src1", out_src1_sel, 2'b00);
    chk("add_src2", out_src2_sel, 2'b00);
    chk("add_rs1", out_rs1, 1);
    chk("add_rs2", out_rs2, 2);
    chk("add_rd", out_rd, 3);
    chk("add_wen", out_rd_wen, 1);
    chk("add_pc", out_pc, 32'h1000);
    chk("add_ill", out_illegal, 0);

    drive(32'h40335293, 32'h1004);            // srai x5,x6,3
    chk("srai_ctl", out_alu_ctl, 4'b1101);
    chk("srai_src2", out_src2_sel, 2'b01);
    chk("srai_imm", out_imm, 3);
    chk("srai_rd", out_rd, 5);
    chk("srai_ill", out_illegal, 0);

    drive(32'h40131293, 32'h1008);            // slli with funct7 0x20
    chk("slli_bad_ill", out_illegal, 1);
    chk("slli_bad_wen", out_rd_wen, 0);
    chk("slli_bad_ctl", out_alu_ctl, 4'b0000);

    drive(32'h0020E463, 32'h100C);            // bltu x1,x2,+8
    chk("bltu_ctl", out_alu_ctl, 4'b0011);
    chk("bltu_imm", out_imm, 8);
    chk("bltu_wen", out_rd_wen, 0);
    chk("bltu_src2", out_src2_sel, 2'b00);

    drive(32'h010000EF, 32'h1010);            // jal x1,16
    chk("jal_src1", out_src1_sel, 2'b01);
    chk("jal_src2", out_src2_sel, 2'b10);
    chk("jal_imm", out_imm, 16);
    chk("jal_wen", out_rd_wen, 1);

    drive(32'h123452B7, 32'h1014);            // lui x5,0x12345
    chk("lui_src1", out_src1_sel, 2'b10);
    chk("lui_imm", out_imm, 32'h12345000);

    drive(32'h0020A223, 32'h1018);            // sw x2,4(x1)
    chk("sw_imm", out_imm, 4);
    chk("sw_src2", out_src2_sel, 2'b01);
    chk("sw_wen", out_rd_wen, 0);

    drive(32'hFFF00093, 32'h101C);            // addi x1,x0,-1
    chk("addi_neg_imm", out_imm, 32'hFFFFFFFF);
    chk("addi_neg_wen", out_rd_wen, 1);

    drive(32'h00000073, 32'h1020);            // ecall
    chk("ecall_ill", out_illegal, 1);

    drive(32'h002088B3, 32'h1024);            // add x17,x1,x2
    chk("x17_ill", out_illegal, c_RV32E);
    chk("x17_wen", out_rd_wen, !c_RV32E);

    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_valid", out_valid, 0);

    // Stream of addi x1,x0,k with out_ready low in cycles 3..5.
    sent = 0; rcvd = 0;
    in_valid = 1'b1; in_inst = 32'h00000093; in_pc = 32'h2000;
    for (int c = 0; c < 30; c++) begin
      out_ready = !(c >= 3 && c <= 5);
      if (c < 10) chk($sformatf("stream_in_ready_c%0d", c), in_ready, !(c >= 4 && c <= 6));
      if (out_valid && out_ready) begin
        chk("stream_pc", out_pc, 32'h2000 + 4 * rcvd);
        chk("stream_imm", out_imm, rcvd);
        rcvd++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
      in_valid = (sent < 8);
      in_inst  = {12'(sent), 5'd0, 3'd0, 5'd1, 7'h13};
      in_pc    = 32'h2000 + 4 * sent;
    end
    chk("stream_sent", sent, 8);
    chk("stream_rcvd", rcvd, 8);
    chk("stream_drained", out_valid, 0);

    // Flush with both entries full and an input pending.
    out_ready = 1'b0;
    drive(32'h00100093, 32'h3000);
    drive(32'h00200093, 32'h3004);
    chk("full_in_ready", in_ready, 0);
    chk("full_pc", out_pc, 32'h3000);
    in_inst = 32'h00300093; in_pc = 32'h3008; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_quiet", out_valid, 0);
    end

    // Flush drops an input offered while in_ready is high.
    out_ready = 1'b0;
    drive(32'h00400093, 32'h4000);
    in_inst = 32'h00500093; in_pc = 32'h4004; in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush2_valid", out_valid, 0);
    chk("flush2_in_ready", in_ready, 1);
    @(negedge clk);
    chk("flush2_dropped", out_valid, 0);

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    drive(32'h002081B3, 32'h5000);
    in_valid = 1'b0;
    chk("pre_arst_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
